// File: rtl/vx_ptw_sched.sv
// vx_ptw_sched: round-robin scheduler that shares one page-table walker among NUM_REQS TLB-miss ports.
// Optional feature macro PTW_SCHED_COALESCE_EN: one walk completes every pending requester with the same VPN.
module vx_ptw_sched #(
    parameter int NUM_REQS       = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int PAGE_SIZE      = 4096,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int VPN_W         = ADDR_WIDTH - $clog2(PAGE_SIZE)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       miss_valid,
    input  logic [NUM_REQS*VPN_W-1:0] miss_vpn,
    output logic [NUM_REQS-1:0]       miss_ready,
    output logic                      walk_req_valid,
    output logic [VPN_W-1:0]          walk_req_vpn,
    input  logic                      walk_req_ready,
    input  logic                      walk_rsp_valid,
    input  logic [VPN_W-1:0]          walk_rsp_ppn,
    input  logic                      walk_rsp_fault,
    output logic [NUM_REQS-1:0]       rsp_valid,
    output logic [VPN_W-1:0]          rsp_ppn,
    output logic                      rsp_fault,
    output logic                      fill_valid,
    output logic [VPN_W-1:0]          fill_vpn,
    output logic [VPN_W-1:0]          fill_ppn,
    output logic                      busy
);
    localparam int RR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RR_W-1:0] RR_LAST = RR_W'(NUM_REQS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t              state, state_nxt;
    logic [NUM_REQS-1:0] pending;
    logic [VPN_W-1:0]    vpn_q [NUM_REQS];
    logic [RR_W-1:0]     rr;
    logic [RR_W-1:0]     g_q;
    logic [VPN_W-1:0]    cur_vpn;
    logic [VPN_W-1:0]    ppn_q;
    logic                fault_q;
    logic [TO_W-1:0]     to_cnt;

    logic                grant_vld;
    logic [RR_W-1:0]     grant_idx;
    logic [NUM_REQS-1:0] done_mask;
    logic                to_hit;

    // First pending slot at or after rr, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            if (!grant_vld && pending[(int'(rr) + k) % NUM_REQS]) begin
                grant_vld = 1'b1;
                grant_idx = RR_W'((int'(rr) + k) % NUM_REQS);
            end
        end
    end

    // Completion set, evaluated on registered pending/vpn_q during RESP.
    always_comb begin
        done_mask      = '0;
        done_mask[g_q] = 1'b1;
`ifdef PTW_SCHED_COALESCE_EN
        for (int j = 0; j < NUM_REQS; j++) begin
            if (pending[j] && (vpn_q[j] == cur_vpn)) done_mask[j] = 1'b1;
        end
`endif
    end

    assign to_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        walk_req_valid = 1'b0;
        rsp_valid      = '0;
        rsp_ppn        = '0;
        rsp_fault      = 1'b0;
        fill_valid     = 1'b0;
        fill_vpn       = '0;
        fill_ppn       = '0;
        case (state)
            S_IDLE:  if (grant_vld) state_nxt = S_ISSUE;
            S_ISSUE: begin
                walk_req_valid = 1'b1;
                if (walk_req_ready) state_nxt = S_WAIT;
            end
            S_WAIT:  if (walk_rsp_valid || to_hit) state_nxt = S_RESP;
            S_RESP: begin
                rsp_valid  = done_mask;
                rsp_ppn    = ppn_q;
                rsp_fault  = fault_q;
                fill_valid = !fault_q;
                if (!fault_q) begin
                    fill_vpn = cur_vpn;
                    fill_ppn = ppn_q;
                end
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            for (int i = 0; i < NUM_REQS; i++) vpn_q[i] <= '0;
            rr      <= '0;
            g_q     <= '0;
            cur_vpn <= '0;
            ppn_q   <= '0;
            fault_q <= 1'b0;
            to_cnt  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (state == S_RESP && done_mask[i]) begin
                    pending[i] <= 1'b0;
                end else if (miss_valid[i] && !pending[i]) begin
                    pending[i] <= 1'b1;
                    vpn_q[i]   <= miss_vpn[i*VPN_W +: VPN_W];
                end
            end
            case (state)
                S_IDLE: if (grant_vld) begin
                    g_q     <= grant_idx;
                    cur_vpn <= vpn_q[grant_idx];
                    rr      <= (grant_idx == RR_LAST) ? '0 : grant_idx + 1'b1;
                end
                S_ISSUE: if (walk_req_ready) to_cnt <= '0;
                S_WAIT: begin
                    if (walk_rsp_valid) begin
                        ppn_q   <= walk_rsp_ppn;
                        fault_q <= walk_rsp_fault;
                    end else if (to_hit) begin
                        ppn_q   <= '0;
                        fault_q <= 1'b1;
                    end else begin
                        to_cnt  <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign miss_ready   = ~pending;
    assign walk_req_vpn = cur_vpn;
    assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_vx_ptw_sched.sv
// Directed bench for vx_ptw_sched (4 requesters, 20-bit VPN, timeout 8 cycles).
module tb_vx_ptw_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  miss_valid;
    logic [79:0] miss_vpn;
    logic [3:0]  miss_ready;
    logic        walk_req_valid;
    logic [19:0] walk_req_vpn;
    logic        walk_req_ready;
    logic        walk_rsp_valid;
    logic [19:0] walk_rsp_ppn;
    logic        walk_rsp_fault;
    logic [3:0]  rsp_valid;
    logic [19:0] rsp_ppn;
    logic        rsp_fault;
    logic        fill_valid;
    logic [19:0] fill_vpn;
    logic [19:0] fill_ppn;
    logic        busy;

    vx_ptw_sched #(.NUM_REQS(4), .ADDR_WIDTH(32), .PAGE_SIZE(4096), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid), .miss_vpn(miss_vpn), .miss_ready(miss_ready),
        .walk_req_valid(walk_req_valid), .walk_req_vpn(walk_req_vpn), .walk_req_ready(walk_req_ready),
        .walk_rsp_valid(walk_rsp_valid), .walk_rsp_ppn(walk_rsp_ppn), .walk_rsp_fault(walk_rsp_fault),
        .rsp_valid(rsp_valid), .rsp_ppn(rsp_ppn), .rsp_fault(rsp_fault),
        .fill_valid(fill_valid), .fill_vpn(fill_vpn), .fill_ppn(fill_ppn), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [3:0]  obs_rsp;
    logic [19:0] obs_ppn, obs_fvpn, obs_fppn;
    logic        obs_fault, obs_fill;
    int          waited;
    logic [3:0]  any_rsp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int i, input logic [19:0] v);
        miss_valid[i]          = 1'b1;
        miss_vpn[i*20 +: 20]   = v;
    endtask

    // Act as a walker: wait for the request, accept it, answer one cycle later, capture RESP outputs.
    task automatic serve(input string tag, input logic [19:0] evpn, input logic [19:0] ppn,
                         input logic flt, output int n);
        n = 0;
        while (!walk_req_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_issue"}, {31'd0, walk_req_valid}, 32'd1);
        check({tag, "_vpn"}, {12'd0, walk_req_vpn}, {12'd0, evpn});
        walk_req_ready = 1'b1;
        tick();
        walk_req_ready = 1'b0;
        walk_rsp_valid = 1'b1;
        walk_rsp_ppn   = ppn;
        walk_rsp_fault = flt;
        tick();
        walk_rsp_valid = 1'b0;
        walk_rsp_fault = 1'b0;
        obs_rsp   = rsp_valid;
        obs_ppn   = rsp_ppn;
        obs_fault = rsp_fault;
        obs_fill  = fill_valid;
        obs_fvpn  = fill_vpn;
        obs_fppn  = fill_ppn;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        miss_valid     = '0;
        miss_vpn       = '0;
        walk_req_ready = 1'b0;
        walk_rsp_valid = 1'b0;
        walk_rsp_ppn   = '0;
        walk_rsp_fault = 1'b0;
        #2;
        check("rst_miss_ready", {28'd0, miss_ready}, 32'hF);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_outs", {25'd0, rsp_valid, walk_req_valid, fill_valid, rsp_fault},  32'd0);
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Single miss, minimum latency
        post(1, 20'h12345);
        tick();
        miss_valid = '0;
        check("t1_ready_after_accept", {28'd0, miss_ready}, 32'b1101);
        serve("t1", 20'h12345, 20'h00ABC, 1'b0, waited);
        check("t1_idle_cycles", waited, 1);
        check("t1_rsp_valid", {28'd0, obs_rsp}, 32'b0010);
        check("t1_rsp_ppn", {12'd0, obs_ppn}, 32'h00ABC);
        check("t1_rsp_fault", {31'd0, obs_fault}, 32'd0);
        check("t1_fill", {11'd0, obs_fill, obs_fvpn}, {11'd0, 1'b1, 20'h12345});
        check("t1_fill_ppn", {12'd0, obs_fppn}, 32'h00ABC);
        tick();
        check("t1_after_rsp", {27'd0, rsp_valid, fill_valid}, 32'd0);
        check("t1_freed", {27'd0, miss_ready, busy}, {27'd0, 4'b1111, 1'b0});

        // Four simultaneous misses from rr=0
        do_reset();
        for (int i = 0; i < 4; i++) post(i, 20'h00100 + 20'(i));
        tick();
        miss_valid = '0;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] m;
            m = 4'b0001 << i;
            serve($sformatf("t2_%0d", i), 20'h00100 + 20'(i), 20'h00200 + 20'(i), 1'b0, waited);
            check($sformatf("t2_rsp_%0d", i), {28'd0, obs_rsp}, {28'd0, m});
            check($sformatf("t2_ppn_%0d", i), {12'd0, obs_ppn}, 32'h00200 + i);
        end
        tick();
        check("t2_all_free", {28'd0, miss_ready}, 32'hF);

        // Duplicate VPN arriving during WAIT
        post(0, 20'h00010);
        tick();
        miss_valid = '0;
        tick();
        check("t3_issue", {12'd0, walk_req_valid, walk_req_vpn}, {12'd0, 1'b1, 20'h00010});
        walk_req_ready = 1'b1;
        tick();
        walk_req_ready = 1'b0;
        post(2, 20'h00010);
        tick();
        miss_valid     = '0;
        walk_rsp_valid = 1'b1;
        walk_rsp_ppn   = 20'h00077;
        tick();
        walk_rsp_valid = 1'b0;
`ifdef PTW_SCHED_COALESCE_EN
        check("t3_rsp_coalesced", {28'd0, rsp_valid}, 32'b0101);
        check("t3_fill", {31'd0, fill_valid}, 32'd1);
        tick();
        tick();
        tick();
        check("t3_no_second_walk", {27'd0, miss_ready, walk_req_valid}, {27'd0, 4'b1111, 1'b0});
`else
        check("t3_rsp_first", {28'd0, rsp_valid}, 32'b0001);
        check("t3_fill", {31'd0, fill_valid}, 32'd1);
        serve("t3b", 20'h00010, 20'h00077, 1'b0, waited);
        check("t3b_rsp", {28'd0, obs_rsp}, 32'b0100);
        check("t3b_fill", {11'd0, obs_fill, obs_fppn}, {11'd0, 1'b1, 20'h00077});
        tick();
`endif

        // Walker fault
        post(3, 20'h0DEAD);
        tick();
        miss_valid = '0;
        serve("t4", 20'h0DEAD, 20'h00123, 1'b1, waited);
        check("t4_rsp", {28'd0, obs_rsp}, 32'b1000);
        check("t4_fault", {31'd0, obs_fault}, 32'd1);
        check("t4_no_fill", {31'd0, obs_fill}, 32'd0);
        tick();
        check("t4_freed", {28'd0, miss_ready}, 32'hF);

        // Timeout, then a late response
        post(1, 20'h00055);
        tick();
        miss_valid = '0;
        tick();
        check("t5_issue", {31'd0, walk_req_valid}, 32'd1);
        walk_req_ready = 1'b1;
        tick();
        walk_req_ready = 1'b0;
        repeat (7) tick();
        check("t5_not_early", {27'd0, rsp_valid, busy}, {27'd0, 4'b0000, 1'b1});
        tick();
        check("t5_rsp", {28'd0, rsp_valid}, 32'b0010);
        check("t5_fault_ppn", {11'd0, rsp_fault, rsp_ppn}, {11'd0, 1'b1, 20'h0});
        check("t5_no_fill", {31'd0, fill_valid}, 32'd0);
        walk_rsp_valid = 1'b1;
        walk_rsp_ppn   = 20'h00999;
        tick();
        walk_rsp_valid = 1'b0;
        check("t5_late_ignored", {27'd0, rsp_valid, busy}, 32'd0);
        tick();
        check("t5_late_quiet", {27'd0, rsp_valid, walk_req_valid}, 32'd0);

        // Reset during WAIT
        post(0, 20'h00020);
        post(2, 20'h00030);
        tick();
        miss_valid = '0;
        tick();
        check("t6_issue", {31'd0, walk_req_valid}, 32'd1);
        walk_req_ready = 1'b1;
        tick();
        walk_req_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_ready", {28'd0, miss_ready}, 32'hF);
        check("t6_async_busy", {30'd0, busy, walk_req_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        walk_rsp_valid = 1'b1;
        walk_rsp_ppn   = 20'h00444;
        any_rsp        = '0;
        tick();
        walk_rsp_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            any_rsp = any_rsp | rsp_valid | {3'b000, fill_valid};
            tick();
        end
        check("t6_no_rsp_after_reset", {28'd0, any_rsp}, 32'd0);
        check("t6_still_free", {27'd0, miss_ready, busy}, {27'd0, 4'b1111, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vx_ptw_sched.md
# vx_ptw_sched

Scheduler that shares one page-table walker among `NUM_REQS` TLB-miss requesters. Each requester posts one outstanding miss (a virtual page number). The block picks requesters round-robin and issues one walk at a time. It returns the translation or fault to every waiting requester and emits a TLB fill. It sits between the per-port TLB miss outputs and the walker's request/response ports.

## Interface
Parameters:
- `NUM_REQS`, 4, number of miss requesters
- `ADDR_WIDTH`, 32, virtual/physical address width
- `PAGE_SIZE`, 4096, page size in bytes (power of two)
- `TIMEOUT_CYCLES`, 1024, walk timeout in cycles; 0 disables timeout
- Derived: `VPN_W = ADDR_WIDTH - log2(PAGE_SIZE)` (20 at defaults)

Ports:
- `clk` in 1: the block's single clock
- `reset` in 1: asynchronous, active-high reset
- `miss_valid` in NUM_REQS: per-requester miss request
- `miss_vpn` in NUM_REQS×VPN_W: missing VPN per requester
- `miss_ready` out NUM_REQS: requester slot empty; request accepted on valid&&ready
- `walk_req_valid` out 1: walk request to walker
- `walk_req_vpn` out VPN_W: VPN to walk
- `walk_req_ready` in 1: walker accepts request
- `walk_rsp_valid` in 1: walk result valid (single-cycle, no back-pressure)
- `walk_rsp_ppn` in VPN_W: resulting physical page number
- `walk_rsp_fault` in 1: walk found no valid mapping
- `rsp_valid` out NUM_REQS: one-cycle completion pulse per requester
- `rsp_ppn` out VPN_W: PPN, shared by all pulsed requesters
- `rsp_fault` out 1: fault flag, shared
- `fill_valid` out 1: one-cycle TLB fill pulse
- `fill_vpn`, `fill_ppn` out VPN_W each: fill entry
- `busy` out 1: state ≠ IDLE

## Operation
- Per requester: `pending[i]` bit and `vpn_q[i]` register. `miss_ready[i] = !pending[i]`. On accept, `pending[i]` is set and `vpn_q[i]` is captured.
- Round-robin pointer `rr` (log2 NUM_REQS bits). Grant goes to the first pending index at or after `rr`, wrapping. On issue, `rr` becomes grant+1 mod NUM_REQS.
- State machine:
  - IDLE: if any pending, latch grant index `g` and `cur_vpn = vpn_q[g]`, then go to ISSUE.
  - ISSUE: `walk_req_valid=1`, `walk_req_vpn=cur_vpn`. On `walk_req_ready`, go to WAIT and clear the timeout counter.
  - WAIT:
    - On `walk_rsp_valid`: latch ppn/fault, go to RESP.
    - Otherwise, if `TIMEOUT_CYCLES≠0` and the counter reaches `TIMEOUT_CYCLES-1`: latch ppn=0, fault=1, go to RESP.
    - Otherwise the counter increments.
  - RESP:
    - Pulse `rsp_valid` for the completion set and clear its `pending` bits.
    - If fault=0, pulse `fill_valid` with `fill_vpn=cur_vpn` and `fill_ppn`.
    - Go to IDLE.
- The completion set is `g` plus the coalesced matches (see Configuration). Matches are evaluated on `pending` / `vpn_q` as registered in the RESP cycle. This includes requests accepted during ISSUE/WAIT and at the edge entering RESP.
- `walk_rsp_valid` outside WAIT is ignored, including a late response after a timeout.
- A slot cleared in RESP shows `miss_ready=1` from the next cycle. A new request can then be accepted at that edge and is eligible in IDLE the cycle after.
- A pending slot's `miss_valid`/`miss_vpn` are ignored until the slot completes.

## Timing
- Reset, asynchronous, effective immediately:
  - State IDLE; all `pending=0`; `rr=0`; timeout counter 0.
  - All outputs 0 except `miss_ready`, which is all 1s.
- Minimum latency, accept edge to `rsp_valid` with walker ready and response one cycle after issue:
  - Edge 0: accept. IDLE cycle. Edge 1 → ISSUE. Edge 2 → WAIT.
  - `walk_rsp_valid` in that cycle. Edge 3 → RESP, pulse. Edge 4 → IDLE.
- At most one walk is outstanding. `walk_req_valid` holds, with stable `walk_req_vpn`, until ready.
- IDLE→ISSUE costs one cycle per walk. Back-to-back walks are spaced at least 4 cycles apart.
- Reset mid-walk abandons it. No `rsp_valid` or `fill_valid` is issued for the abandoned walk, and the walker's later response is ignored.

## Configuration
- `PTW_SCHED_COALESCE_EN` defined: the completion set is `g` plus every `j≠g` with `pending[j]` and `vpn_q[j]==cur_vpn`. All of them receive the same ppn/fault in one RESP cycle. One fill is issued.
- Not defined: the completion set is `g` only. Duplicate VPNs trigger separate walks and separate identical fills.

## Test plan
- Single miss on requester 1, vpn 0x12345; walker ready, returns ppn 0x00ABC one cycle after issue. Required: `rsp_valid=4'b0010` 3 cycles after accept, ppn 0x00ABC, fault 0; fill 0x12345→0x00ABC.
- All four requesters miss in the same cycle with distinct VPNs, starting from `rr=0`. Required: walks issued in order 0,1,2,3; each requester gets exactly one pulse.
- With COALESCE_EN, requesters 0 and 2 both miss vpn 0x00010, requester 2 three cycles later during WAIT. Required: one walk, `rsp_valid=4'b0101` in a single cycle, one fill. Without the macro: two walks and two fills.
- Walker returns fault=1. Required: `rsp_fault=1`, `fill_valid` stays 0, slot freed.
- `TIMEOUT_CYCLES=8`, walker never responds. Required: RESP 8 cycles after entering WAIT with fault=1, ppn=0. A `walk_rsp_valid` arriving afterwards causes no pulse.
- Assert reset during WAIT. Required: all `pending` cleared, `miss_ready=4'b1111`, `busy=0` with no clock edge needed, and no later `rsp_valid`.
